// File: rtl/ram8_16_if.sv
// Data/address bus for the 8x16 register memory: write data, load strobe, address, read data.
// The testbench drives the master side and the memory sits on the slave side.
interface ram8_16_if;
    logic [0:15] in_a;
    logic        in_load;
    logic [0:2]  in_addr;
    logic [0:15] out_y;

    modport master (
        output in_a,
        output in_load,
        output in_addr,
        input  out_y
    );

    modport slave (
        input  in_a,
        input  in_load,
        input  in_addr,
        output out_y
    );
endinterface

// File: rtl/ram8_16.sv
// 8-word x 16-bit register memory: decoded per-word load strobes, hold/load word registers,
// and a combinational 8-way mux tree on the read side. Leaf of the RAM64/RAM512 hierarchy.
module ram8_16 (
    input  logic           in_clk,
    input  logic           in_rst,
    ram8_16_if.slave       bus
);
    localparam int unsigned N     = 16;
    localparam int unsigned Depth = 8;

    logic [Depth-1:0] load_line;
    logic [0:N-1]     word_q [Depth];
    logic [0:N-1]     word_d [Depth];

    // demux8way: in_load lands on exactly one line; an unknown address cannot raise a strobe
    // while in_load is low because the whole vector stays zero.
    always_comb begin
        load_line = '0;
        if (bus.in_load) begin
            load_line[bus.in_addr] = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < Depth; i++) begin
            word_d[i] = load_line[i] ? bus.in_a : word_q[i];
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            for (int i = 0; i < Depth; i++) begin
                word_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < Depth; i++) begin
                word_q[i] <= word_d[i];
            end
        end
    end

    // Read tree: first level on the LSB (in_addr[2]), last level on the MSB (in_addr[0]).
    logic [0:N-1] lvl1 [4];
    logic [0:N-1] lvl2 [2];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lvl1[i] = bus.in_addr[2] ? word_q[2*i+1] : word_q[2*i];
        end
        for (int i = 0; i < 2; i++) begin
            lvl2[i] = bus.in_addr[1] ? lvl1[2*i+1] : lvl1[2*i];
        end
    end

    assign bus.out_y = bus.in_addr[0] ? lvl2[1] : lvl2[0];
endmodule
